// File: rtl/pc_fetch_queue_if.sv
// Instruction-memory fetch port shared by pc_fetch_queue (master) and the
// instruction ROM/bus (slave). Request/address hold until acknowledged.
interface pc_fetch_queue_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/pc_fetch_queue.sv
// IF-stage PC generator with a DEPTH-entry {pc, instr} prefetch queue.
// One fetch outstanding at a time; flush/redirect empty the queue and retarget
// the PC, discarding the data of a request that is still in flight.
// Optional build macro PC_ALIGN_CHK_EN: a misaligned target pushes a single
// marker entry (if_excp_misalign=1) and halts fetching until the next
// flush/redirect. Without it, the target's low bits are cleared.
//
// state  | meaning
// S_IDLE | no request held; a new fetch may issue this cycle
// S_WAIT | request held on the bus, its data will be queued
// S_DROP | request held on the bus, its data will be discarded
module pc_fetch_queue #(
    parameter int              ADDR_W      = 32,
    parameter int              DATA_W      = 32,
    parameter int              DEPTH       = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int              INSTR_BYTES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [5:0]                 stall,
    input  logic                       flush,
    input  logic [ADDR_W-1:0]          flush_pc,
    input  logic                       redirect_valid,
    input  logic [ADDR_W-1:0]          redirect_pc,
    pc_fetch_queue_if.master           imem,
    output logic                       if_valid,
    output logic [ADDR_W-1:0]          if_pc,
    output logic [DATA_W-1:0]          if_instr,
    output logic                       if_excp_misalign,
    output logic [$clog2(DEPTH+1)-1:0] fq_count
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] PC_INC     = ADDR_W'(INSTR_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INSTR_BYTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} fetch_state_t;

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] addr_q;
    logic              halted;
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count;

    logic [ADDR_W-1:0] pc_q     [DEPTH];
    logic [DATA_W-1:0] instr_q  [DEPTH];
    logic              mis_q    [DEPTH];

    logic              redir, ack, push, pop, load_mis, tgt_mis, held;
    logic [ADDR_W-1:0] target, tgt_use;
    logic              unused_stall;

    assign unused_stall = ^stall[5:1];

    // target selection, issue gating and queue handshake qualifiers
    always_comb begin
        redir    = flush | redirect_valid;
        target   = flush ? flush_pc : redirect_pc;
        tgt_mis  = |(target & ALIGN_MASK);
`ifdef PC_ALIGN_CHK_EN
        tgt_use  = target;
        load_mis = redir & tgt_mis;
`else
        tgt_use  = target & ~ALIGN_MASK;
        load_mis = 1'b0;
`endif
        held           = (state != S_IDLE);
        imem.imem_req  = rst & (held | (~halted & (count < FULL_CNT) & ~redir));
        imem.imem_addr = held ? addr_q : fetch_pc;
        ack            = imem.imem_ack & imem.imem_req;
        push           = ack & (state != S_DROP) & ~redir;
        if_valid       = (count != '0);
        pop            = if_valid & ~stall[0] & ~redir;
    end

    // fetch handshake state register
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // fetch handshake next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (imem.imem_req && !ack) state_nxt = S_WAIT;
            S_WAIT:  if (ack) state_nxt = S_IDLE;
                     else if (redir) state_nxt = S_DROP;
            S_DROP:  if (ack) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // PC sequencing, held address and queue pointers
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            addr_q   <= RESET_PC;
            halted   <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (imem.imem_req && state == S_IDLE) addr_q <= fetch_pc;
            if (redir) begin
                fetch_pc <= tgt_use;
                halted   <= load_mis;
                rd_ptr   <= '0;
                wr_ptr   <= load_mis ? PTR_W'(1) : '0;
                count    <= load_mis ? CNT_W'(1) : '0;
            end else begin
                if (push) begin
                    fetch_pc <= fetch_pc + PC_INC;
                    wr_ptr   <= wr_ptr + PTR_W'(1);
                end
                if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // queue storage; the misalign marker always lands in slot 0 of an empty queue
    always_ff @(posedge clk) begin
        if (load_mis) begin
            pc_q[0]    <= target;
            instr_q[0] <= '0;
            mis_q[0]   <= 1'b1;
        end else if (push) begin
            pc_q[wr_ptr]    <= imem.imem_addr;
            instr_q[wr_ptr] <= imem.imem_rdata;
            mis_q[wr_ptr]   <= 1'b0;
        end
    end

    // head-of-queue outputs, zeroed when empty
    always_comb begin
        if_pc            = if_valid ? pc_q[rd_ptr] : '0;
        if_instr         = if_valid ? instr_q[rd_ptr] : '0;
        if_excp_misalign = if_valid & mis_q[rd_ptr];
        fq_count         = count;
    end
endmodule

// File: tb/tb_pc_fetch_queue.sv
// Directed bench for pc_fetch_queue: streaming/fill table plus hand sequences
// for wait states, redirect during a wait, flush priority, alignment and reset.
module tb_pc_fetch_queue;
    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  stall = '0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid, if_excp_misalign;
    logic [31:0] if_pc, if_instr;
    logic [2:0]  fq_count;

    logic        if_valid_w, if_mis_w;
    logic [31:0] if_pc_w, if_instr_w;
    logic [2:0]  fq_count_w;

    logic        force_ack = 1'b0;
    logic [31:0] wait_addr = 32'hFFFF_FFF0;
    int          wait_cycles = 0;
    int          wcnt = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    pc_fetch_queue_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    pc_fetch_queue_if #(.ADDR_W(32), .DATA_W(32)) bus_w ();

    assign bus.imem_ack   = force_ack | (bus.imem_req &&
                            (bus.imem_addr != wait_addr || wcnt >= wait_cycles));
    assign bus.imem_rdata = bus.imem_addr ^ K;
    assign bus_w.imem_ack   = bus_w.imem_req;
    assign bus_w.imem_rdata = bus_w.imem_addr;

    always @(posedge clk) begin
        if (bus.imem_req && !bus.imem_ack) wcnt <= wcnt + 1;
        else                               wcnt <= 0;
    end

    pc_fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0),
                     .INSTR_BYTES(4)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_pc(flush_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .imem(bus),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .if_excp_misalign(if_excp_misalign), .fq_count(fq_count));

    pc_fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFFC),
                     .INSTR_BYTES(4)) dut_w (
        .clk(clk), .rst(rst), .stall(6'b0), .flush(1'b0), .flush_pc(32'h0),
        .redirect_valid(1'b0), .redirect_pc(32'h0), .imem(bus_w),
        .if_valid(if_valid_w), .if_pc(if_pc_w), .if_instr(if_instr_w),
        .if_excp_misalign(if_mis_w), .fq_count(fq_count_w));

    typedef struct {
        logic        stall0;
        logic        force_ack;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [2:0]  exp_cnt;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic chk_head(input string name, input logic v, input logic [31:0] pc);
        chk({name, "_valid"}, if_valid, v);
        chk({name, "_pc"}, if_pc, v ? pc : 32'h0);
        chk({name, "_instr"}, if_instr, v ? (pc ^ K) : 32'h0);
    endtask

    task automatic chk_req(input string name, input logic r, input logic [31:0] a);
        chk({name, "_req"}, bus.imem_req, r);
        chk({name, "_addr"}, bus.imem_addr, a);
    endtask

    initial begin
        //            stall0 force req addr      valid pc        cnt
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00, 3'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 32'h04, 1'b1, 32'h00, 3'd1};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'h08, 1'b1, 32'h04, 3'd1};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h08, 3'd1};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 32'h0C, 3'd1};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 32'h14, 1'b1, 32'h0C, 3'd2};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 32'h18, 1'b1, 32'h0C, 3'd3};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h1C, 1'b1, 32'h0C, 3'd4};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h1C, 1'b1, 32'h0C, 3'd4};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h1C, 1'b1, 32'h10, 3'd3};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h20, 1'b1, 32'h14, 3'd3};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h24, 1'b1, 32'h18, 3'd3};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 32'h28, 1'b1, 32'h1C, 3'd3};

        // reset state
        repeat (2) step();
        samp();
        chk_req("rst", 1'b0, 32'h0);
        chk_head("rst", 1'b0, 32'h0);
        chk("rst_mis", if_excp_misalign, 1'b0);
        chk("rst_cnt", fq_count, 3'd0);

        // streaming, fill to full, ack with no request, release
        for (int i = 0; i < 13; i++) begin
            step();
            rst       = 1'b1;
            stall[0]  = vecs[i].stall0;
            force_ack = vecs[i].force_ack;
            samp();
            chk_req($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr);
            chk_head($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pc);
            chk($sformatf("vec%0d_cnt", i), fq_count, vecs[i].exp_cnt);
            chk($sformatf("wrap%0d_addr", i), bus_w.imem_addr, 32'hFFFF_FFFC + 32'(4 * i));
        end
        force_ack = 1'b0;

        // redirect to 0 with nothing outstanding, then 3 wait states on 0x8
        step(); redirect_valid = 1'b1; redirect_pc = 32'h0; wait_addr = 32'h8; wait_cycles = 3;
        samp(); chk("redir_req_off", bus.imem_req, 1'b0);
        step(); redirect_valid = 1'b0;
        samp(); chk_req("lat1", 1'b1, 32'h0); chk_head("lat1", 1'b0, 32'h0);
        step(); samp(); chk_req("lat2", 1'b1, 32'h4); chk_head("lat2", 1'b1, 32'h0);
        step(); samp(); chk_req("ws0", 1'b1, 32'h8); chk_head("ws0", 1'b1, 32'h4);
        for (int k = 1; k <= 3; k++) begin
            step(); samp();
            chk_req($sformatf("ws%0d", k), 1'b1, 32'h8);
            chk_head($sformatf("ws%0d", k), 1'b0, 32'h0);
        end
        step(); wait_addr = 32'h10; wait_cycles = 1000;
        samp(); chk_req("ws_done", 1'b1, 32'hC); chk_head("ws_done", 1'b1, 32'h8);
        step(); samp(); chk_req("ws_next", 1'b1, 32'h10); chk_head("ws_next", 1'b1, 32'hC);

        // redirect to 0x100 while 0x10 is unacked
        step(); redirect_valid = 1'b1; redirect_pc = 32'h100;
        samp(); chk_req("rmw0", 1'b1, 32'h10); chk_head("rmw0", 1'b0, 32'h0);
        step(); redirect_valid = 1'b0; wait_cycles = 0;
        samp(); chk_req("rmw_hold", 1'b1, 32'h10); chk("rmw_hold_cnt", fq_count, 3'd0);
        step(); samp(); chk_req("rmw_tgt", 1'b1, 32'h100); chk_head("rmw_tgt", 1'b0, 32'h0);
        chk("rmw_tgt_cnt", fq_count, 3'd0);
        step(); samp(); chk_head("rmw_head", 1'b1, 32'h100);

        // flush and redirect together while popping
        flush = 1'b1; flush_pc = 32'h180; redirect_valid = 1'b1; redirect_pc = 32'h200;
        step(); flush = 1'b0; redirect_valid = 1'b0;
        samp(); chk_head("prio", 1'b0, 32'h0); chk_req("prio", 1'b1, 32'h180);
        chk("prio_cnt", fq_count, 3'd0);

        // misaligned redirect target
        step(); redirect_valid = 1'b1; redirect_pc = 32'h102;
        samp(); chk_head("prio_head", 1'b1, 32'h180);
        step(); redirect_valid = 1'b0;
        samp();
`ifdef PC_ALIGN_CHK_EN
        chk("mis_req", bus.imem_req, 1'b0);
        chk("mis_valid", if_valid, 1'b1);
        chk("mis_pc", if_pc, 32'h102);
        chk("mis_instr", if_instr, 32'h0);
        chk("mis_flag", if_excp_misalign, 1'b1);
        chk("mis_cnt", fq_count, 3'd1);
        step(); samp();
        chk("mis_halt_req", bus.imem_req, 1'b0);
        chk("mis_halt_valid", if_valid, 1'b0);
`else
        chk_req("algn", 1'b1, 32'h100);
        chk("algn_valid", if_valid, 1'b0);
        step(); samp();
        chk_head("algn_head", 1'b1, 32'h100);
        chk("algn_flag", if_excp_misalign, 1'b0);
`endif

        // flush resumes fetching; then reset abandons a pending request
        step(); flush = 1'b1; flush_pc = 32'h200; wait_addr = 32'h204; wait_cycles = 1000;
        samp();
        step(); flush = 1'b0;
        samp(); chk_req("resume", 1'b1, 32'h200); chk("resume_valid", if_valid, 1'b0);
        step(); samp(); chk_req("pend", 1'b1, 32'h204); chk_head("pend", 1'b1, 32'h200);
        step(); rst = 1'b0;
        samp(); chk("rst_mid_req", bus.imem_req, 1'b0);
        step(); rst = 1'b1; wait_addr = 32'hFFFF_FFF0;
        samp(); chk_req("rst_mid", 1'b1, 32'h0); chk_head("rst_mid", 1'b0, 32'h0);
        chk("rst_mid_cnt", fq_count, 3'd0);
        step(); samp(); chk_head("rst_mid_head", 1'b1, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
